// File: rtl/decodificador_teclado_matricial.sv
// Matrix keypad scanner/decoder with press/release debounce, typematic repeat,
// release pulse and multi-key (ghost) rejection. Row drive is active-low.
module decodificador_teclado_matricial #(
  parameter int N_LIN          = 4,
  parameter int N_COL          = 4,
  parameter int DEBOUNCE_P     = 100,
  parameter int SCAN_P         = 4,
  parameter int REPEAT_DELAY_P = 0,
  parameter int REPEAT_RATE_P  = 200,
  localparam int VW            = $clog2(N_LIN*N_COL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_COL-1:0] col_matriz,
  output logic [N_LIN-1:0] lin_matriz,
  output logic [VW-1:0]    tecla_value,
  output logic             tecla_valid,
  output logic             tecla_release,
  output logic             tecla_erro,
  output logic [1:0]       dbg_state
);

  localparam int RW    = $clog2(N_LIN);
  localparam int CCW   = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int SW    = $clog2(SCAN_P);
  localparam int MAX_A = (DEBOUNCE_P > REPEAT_DELAY_P) ? DEBOUNCE_P : REPEAT_DELAY_P;
  localparam int MAX_C = (MAX_A > REPEAT_RATE_P) ? MAX_A : REPEAT_RATE_P;
  localparam int CW    = $clog2(MAX_C) + 1;

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [N_COL-1:0] col_s1, col_s, pat;
  logic [1:0]       state;
  logic [RW-1:0]    row, row_next;
  logic [SW-1:0]    dwell;
  logic [CW-1:0]    cnt, rcnt, cnt_inc, rcnt_inc, rep_target;
  logic [CCW-1:0]   col_lat, low_idx;
  logic             key_ok, rep_phase;
  logic             one_low, multi_low, flushed;
  int               n_low;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_comb begin
    n_low   = 0;
    low_idx = '0;
    for (int c = 0; c < N_COL; c++) begin
      if (!col_s[c]) begin
        n_low   = n_low + 1;
        low_idx = CCW'(c);
      end
    end
  end

  assign one_low    = (n_low == 1);
  assign multi_low  = (n_low > 1);
  // The first two cycles of a row dwell still carry the previous row's columns.
  assign flushed    = (dwell >= SW'(2));
  assign row_next   = (row == RW'(N_LIN-1)) ? '0 : row + RW'(1);
  assign cnt_inc    = sat_inc(cnt);
  assign rcnt_inc   = sat_inc(rcnt);
  assign rep_target = rep_phase ? CW'(REPEAT_RATE_P) : CW'(REPEAT_DELAY_P);
  assign lin_matriz = ~(N_LIN'(1) << row);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1        <= '1;
      col_s         <= '1;
      pat           <= '1;
      state         <= S_SCAN;
      row           <= '0;
      dwell         <= '0;
      cnt           <= '0;
      rcnt          <= '0;
      col_lat       <= '0;
      key_ok        <= 1'b0;
      rep_phase     <= 1'b0;
      tecla_value   <= '0;
      tecla_valid   <= 1'b0;
      tecla_release <= 1'b0;
      tecla_erro    <= 1'b0;
    end else begin
      col_s1        <= col_matriz;
      col_s         <= col_s1;
      tecla_valid   <= 1'b0;
      tecla_release <= 1'b0;
      tecla_erro    <= 1'b0;
      case (state)
        S_SCAN: begin
          if (flushed && one_low) begin
            pat     <= col_s;
            col_lat <= low_idx;
            cnt     <= CW'(1);
            state   <= S_DEBOUNCE;
          end else if (flushed && multi_low) begin
            tecla_erro <= 1'b1;
            key_ok     <= 1'b0;
            cnt        <= '0;
            state      <= S_RELEASE;
          end else if (dwell == SW'(SCAN_P-1)) begin
            dwell <= '0;
            row   <= row_next;
          end else begin
            dwell <= dwell + SW'(1);
          end
        end
        S_DEBOUNCE: begin
          if (col_s != pat) begin
            cnt   <= '0;
            dwell <= '0;
            row   <= row_next;
            state <= S_SCAN;
          end else if (cnt == CW'(DEBOUNCE_P-1)) begin
            tecla_valid <= 1'b1;
            tecla_value <= VW'(row) * VW'(N_COL) + VW'(col_lat);
            key_ok      <= 1'b1;
            cnt         <= '0;
            rcnt        <= '0;
            rep_phase   <= 1'b0;
            state       <= S_PRESSED;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_PRESSED: begin
          // A pattern change wins over a repeat that would fire in the same cycle.
          if (col_s != pat) begin
            cnt   <= '0;
            state <= S_RELEASE;
          end else if (REPEAT_DELAY_P != 0 && rcnt_inc == rep_target) begin
            tecla_valid <= 1'b1;
            rcnt        <= '0;
            rep_phase   <= 1'b1;
          end else begin
            rcnt <= rcnt_inc;
          end
        end
        default: begin
          if (!(&col_s)) begin
            cnt <= '0;
          end else if (cnt == CW'(DEBOUNCE_P-1)) begin
            tecla_release <= key_ok;
            key_ok        <= 1'b0;
            cnt           <= '0;
            dwell         <= '0;
            row           <= row_next;
            state         <= S_SCAN;
          end else begin
            cnt <= cnt_inc;
          end
        end
      endcase
    end
  end

endmodule
